// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 operand/result selector.
package mux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux_4_1_if.sv
// Bus bundle between the ALU datapath and the 4:1 selector.
interface mux_4_1_if
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   sel_t             s;
   logic             in_valid;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic             out_valid;

   modport master (
      output a, b, c, d, s, in_valid,
      input  out, out_q, out_valid
   );

   modport slave (
      input  a, b, c, d, s, in_valid,
      output out, out_q, out_valid
   );
endinterface

// File: rtl/mux_4_1_comb.sv
// Purely combinational WIDTH-bit 4:1 selector.
module mux_4_1_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   input  sel_t             i_s,
   output logic [WIDTH-1:0] o_out
);

   // An unknown select propagates as all-X in simulation; synthesis may treat it as don't-care.
   always_comb begin
      o_out = 'x;
      case (i_s)
         SEL_A:   o_out = i_a;
         SEL_B:   o_out = i_b;
         SEL_C:   o_out = i_c;
         SEL_D:   o_out = i_d;
         default: o_out = 'x;
      endcase
   end

endmodule

// File: rtl/mux_4_1.sv
// 4:1 selector with a combinational output and a registered, valid-qualified copy.
module mux_4_1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_4_1_if.slave   bus
);

   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;
   logic             r_out_valid;

   mux_4_1_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .i_a   (bus.a),
      .i_b   (bus.b),
      .i_c   (bus.c),
      .i_d   (bus.d),
      .i_s   (bus.s),
      .o_out (w_out)
   );

   // Data holds when no valid input arrives; the flag is a single-cycle pulse per capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_q     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_out_q <= w_out;
         end
      end
   end

   assign bus.out       = w_out;
   assign bus.out_q     = r_out_q;
   assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_4_1.sv
// Directed bench for mux_4_1: a 1-bit instance for selection, an 8-bit instance for the register path.
module tb_mux_4_1;
   import mux_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_4_1_if #(.WIDTH(1)) bus1 ();
   mux_4_1_if #(.WIDTH(8)) bus8 ();

   mux_4_1 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   mux_4_1 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_q [4];
      checks = 0;
      errors = 0;
      exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;

      rst_n = 1'b0;
      bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b0;
      bus1.s = SEL_A; bus1.in_valid = 1'b0;
      bus8.a = 8'h11; bus8.b = 8'h22; bus8.c = 8'h33; bus8.d = 8'h44;
      bus8.s = SEL_A; bus8.in_valid = 1'b0;
      #1;
      chk("rst_out_q",     bus8.out_q, 8'h00);
      chk("rst_out_valid", {7'd0, bus8.out_valid}, 8'h00);
      chk("rst_out_comb",  bus8.out, 8'h11);

      // 1-bit selection vectors
      bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b0; bus1.s = 2'b00; #1;
      chk("w1_sel_a_one",  {7'd0, bus1.out}, 8'h01);
      bus1.a = 1'b0; bus1.b = 1'b1; bus1.c = 1'b1; bus1.d = 1'b1; bus1.s = 2'b00; #1;
      chk("w1_sel_a_zero", {7'd0, bus1.out}, 8'h00);
      bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b1; bus1.d = 1'b1; bus1.s = 2'b01; #1;
      chk("w1_walk0_b",    {7'd0, bus1.out}, 8'h00);
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b0; bus1.d = 1'b1; bus1.s = 2'b10; #1;
      chk("w1_walk0_c",    {7'd0, bus1.out}, 8'h00);
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1; bus1.d = 1'b0; bus1.s = 2'b11; #1;
      chk("w1_walk0_d",    {7'd0, bus1.out}, 8'h00);
      bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b1; bus1.s = 2'b01; #1;
      chk("w1_d_only_s01", {7'd0, bus1.out}, 8'h00);
      bus1.s = 2'b11; #1;
      chk("w1_d_only_s11", {7'd0, bus1.out}, 8'h01);

      // out ignores in_valid and reset
      bus8.in_valid = 1'b1; bus8.s = SEL_C; #1;
      chk("comb_in_reset", bus8.out, 8'h33);
      bus8.in_valid = 1'b0; bus8.s = SEL_A;

      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back captures, s cycling 00..11
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus8.s = sel_t'(i);
         bus8.in_valid = 1'b1;
         #1;
         chk("pipe_comb", bus8.out, exp_q[i]);
         @(posedge clk);
         #1;
         chk("pipe_out_q",     bus8.out_q, exp_q[i]);
         chk("pipe_out_valid", {7'd0, bus8.out_valid}, 8'h01);
      end

      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.s = SEL_A;
      @(posedge clk); #1;
      chk("idle_valid", {7'd0, bus8.out_valid}, 8'h00);
      chk("idle_hold",  bus8.out_q, 8'h44);
      @(posedge clk); #1;
      chk("idle_hold2", bus8.out_q, 8'h44);

      // asynchronous reset between edges
      @(negedge clk); #2;
      bus8.s = SEL_B;
      rst_n = 1'b0;
      #1;
      chk("async_rst_q",     bus8.out_q, 8'h00);
      chk("async_rst_valid", {7'd0, bus8.out_valid}, 8'h00);
      chk("async_rst_comb",  bus8.out, 8'h22);
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_blocks_capture", bus8.out_q, 8'h00);

      @(negedge clk);
      rst_n = 1'b1;
      bus8.s = SEL_D;
      @(posedge clk); #1;
      chk("first_after_rst_q",     bus8.out_q, 8'h44);
      chk("first_after_rst_valid", {7'd0, bus8.out_valid}, 8'h01);
      @(negedge clk);
      bus8.in_valid = 1'b0;

      // unknown select
      bus8.s = 2'bx0;
      #1;
      if ($isunknown(bus8.s)) begin
         chk("x_select", bus8.out, 8'hxx);
      end
      bus8.s = 2'b10;
      #1;
      chk("x_recover", bus8.out, 8'h33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
